// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - execute stage: registered RV32I ALU plus iterative M-extension multiply/divide
module ex_stage_mdu #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;

  logic [XLEN-1:0]        op_b, alu_val, a_mag, b_mag, fast_val;
  logic signed [XLEN-1:0] sra_val;
  logic [SHW-1:0]         shamt, cnt;
  logic                   accept, is_m, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, last;

  // iteration state, loaded at accept
  logic [1:0]          f3;
  logic                res_neg;
  logic [2*XLEN-1:0]   acc, mcand, acc_nx, prod;
  logic [XLEN-1:0]     mplier, rem_r, quo, dvsr;
  logic [XLEN:0]       rsh;
  logic                ge;
  logic [XLEN-1:0]     rem_nx, quo_nx, div_res, div_fin, mul_fin;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign op_b     = alu_src ? imm : rs2_data;
  assign shamt    = op_b[SHW-1:0];
  assign sra_val  = $signed(rs1_data) >>> shamt;
  assign is_m     = ENABLE_M && (alu_op == 2'b10) && !alu_src && (funct7 == 7'b0000001);

  always_comb begin
    alu_val = rs1_data + op_b;
    if (alu_op == 2'b01) alu_val = rs1_data - op_b;
    else if (alu_op == 2'b10) begin
      case (funct3)
        3'b000:  if (funct7[5] && !alu_src) alu_val = rs1_data - op_b;
        3'b001:  alu_val = rs1_data << shamt;
        3'b010:  alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(op_b)};
        3'b011:  alu_val = {{(XLEN-1){1'b0}}, rs1_data < op_b};
        3'b100:  alu_val = rs1_data ^ op_b;
        3'b101:  alu_val = funct7[5] ? sra_val : rs1_data >> shamt;
        3'b110:  alu_val = rs1_data | op_b;
        default: alu_val = rs1_data & op_b;
      endcase
    end
  end

  // Operand signedness: MUL/MULH/MULHSU sign rs1, MUL/MULH sign rs2, DIV/REM sign both.
  assign a_sgn    = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign b_sgn    = funct3[2] ? !funct3[0] : !funct3[1];
  assign a_neg    = a_sgn && rs1_data[XLEN-1];
  assign b_neg    = b_sgn && rs2_data[XLEN-1];
  assign a_mag    = a_neg ? -rs1_data : rs1_data;
  assign b_mag    = b_neg ? -rs2_data : rs2_data;
  assign div_zero = (rs2_data == '0);
  assign div_ovf  = !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data);
  assign fast_val = funct3[1] ? (div_zero ? rs1_data : '0) : (div_zero ? '1 : rs1_data);

  assign acc_nx  = acc + (mplier[0] ? mcand : '0);
  assign prod    = res_neg ? -acc_nx : acc_nx;
  assign mul_fin = (f3 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring step: the difference fits XLEN bits whenever it is kept.
  assign rsh     = {rem_r, quo[XLEN-1]};
  assign ge      = rsh >= {1'b0, dvsr};
  assign rem_nx  = ge ? rsh[XLEN-1:0] - dvsr : rsh[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], ge};
  assign div_res = f3[1] ? rem_nx : quo_nx;
  assign div_fin = res_neg ? -div_res : div_res;
  assign last    = (cnt == SHW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          f3      <= funct3[1:0];
          res_neg <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          cnt     <= '0;
          if (is_m && !funct3[2]) begin
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            state  <= MUL;
            busy   <= 1'b1;
          end else if (is_m && !(div_zero || div_ovf)) begin
            rem_r <= '0;
            quo   <= a_mag;
            dvsr  <= b_mag;
            state <= DIV;
            busy  <= 1'b1;
          end else begin
            out_valid  <= 1'b1;
            alu_result <= is_m ? fast_val : alu_val;
            zero       <= ((is_m ? fast_val : alu_val) == '0);
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            out_valid  <= 1'b1;
            alu_result <= mul_fin;
            zero       <= (mul_fin == '0);
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        DIV: begin
          rem_r <= rem_nx;
          quo   <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            out_valid  <= 1'b1;
            alu_result <= div_fin;
            zero       <= (div_fin == '0);
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - vector table, random ops vs arithmetic model, backpressure and reset sequences
`timescale 1ns/1ps
module tb_ex_stage_mdu;
  logic        clk, rst, in_valid, in_ready, alu_src, out_valid, out_ready, zero, busy;
  logic [31:0] rs1_data, rs2_data, imm, alu_result;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int n_pass = 0;
  int n_tot  = 0;

  ex_stage_mdu #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2ms");
    $fatal(1);
  end

  typedef struct {
    logic        src;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, i, exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endfunction

  // Reference: RISC-V semantics via plain integer arithmetic.
  function automatic void model(input logic src, input logic [1:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] i, output logic [31:0] r, output int lat);
    logic [31:0] bb;
    int          sa, sb, sbb;
    longint      p;
    logic [63:0] up;
    bb  = src ? i : b;
    sa  = $signed(a);
    sb  = $signed(b);
    sbb = $signed(bb);
    lat = 1;
    if (op == 2'b10 && !src && f7 == 7'h01) begin
      lat = 33;
      case (f3)
        3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
        3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
        3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
        3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
        3'd4: if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; lat = 1; end
              else r = 32'(sa / sb);
        3'd5: if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end else r = a / b;
        3'd6: if (b == 0) begin r = a; lat = 1; end
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; lat = 1; end
              else r = 32'(sa % sb);
        default: if (b == 0) begin r = a; lat = 1; end else r = a % b;
      endcase
    end else if (op == 2'b01) r = a - bb;
    else if (op != 2'b10) r = a + bb;
    else begin
      case (f3)
        3'd0: r = (f7[5] && !src) ? a - bb : a + bb;
        3'd1: r = a << bb[4:0];
        3'd2: r = {31'b0, sa < sbb};
        3'd3: r = {31'b0, a < bb};
        3'd4: r = a ^ bb;
        3'd5: r = f7[5] ? $signed(a) >>> bb[4:0] : a >> bb[4:0];
        3'd6: r = a | bb;
        default: r = a & bb;
      endcase
    end
  endfunction

  task automatic run_op(input logic src, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic [31:0] exp, input int exp_lat,
                        input string tag);
    int n;
    bit busy_ok;
    @(negedge clk);
    alu_src = src; alu_op = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = i; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_accept"}, {31'b0, n < 100}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
    busy_ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && (busy !== 1'b1 || in_ready !== 1'b0)) busy_ok = 1'b0;
    end while (!out_valid && n < 100);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, alu_result, exp);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 0});
    if (exp_lat > 1) check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    logic        src;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, i, exp;
    int          lat, kind;
    bit          ok;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_src = 1'b0; alu_op = 2'b00;
    funct3 = 3'b000; funct7 = 7'h00; rs1_data = '0; rs2_data = '0; imm = '0;

    vecs[0]  = '{1'b0, 2'b00, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0, 32'd30, 1};
    vecs[1]  = '{1'b0, 2'b10, 3'd0, 7'h20, 32'd10, 32'd20, 32'd0, 32'hFFFFFFF6, 1};
    vecs[2]  = '{1'b0, 2'b10, 3'd0, 7'h20, 32'd20, 32'd20, 32'd0, 32'd0, 1};
    vecs[3]  = '{1'b1, 2'b10, 3'd4, 7'h00, 32'd10, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h0F0F0F05, 1};
    vecs[4]  = '{1'b1, 2'b10, 3'd0, 7'h20, 32'd5, 32'd100, 32'd3, 32'd8, 1};
    vecs[5]  = '{1'b0, 2'b10, 3'd5, 7'h20, 32'hFFFFFFF8, 32'd1, 32'd0, 32'hFFFFFFFC, 1};
    vecs[6]  = '{1'b0, 2'b10, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1};
    vecs[7]  = '{1'b0, 2'b10, 3'd2, 7'h00, 32'hFFFFFFFB, 32'd10, 32'd0, 32'd1, 1};
    vecs[8]  = '{1'b0, 2'b10, 3'd0, 7'h01, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 33};
    vecs[9]  = '{1'b0, 2'b10, 3'd1, 7'h01, 32'hFFFFFFF8, 32'd3, 32'd0, 32'hFFFFFFFF, 33};
    vecs[10] = '{1'b0, 2'b10, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 33};
    vecs[11] = '{1'b0, 2'b10, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFD, 33};
    vecs[12] = '{1'b0, 2'b10, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, 32'd0, 32'hFFFFFFFF, 33};
    vecs[13] = '{1'b0, 2'b10, 3'd5, 7'h01, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 1};
    vecs[14] = '{1'b0, 2'b10, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1};
    vecs[15] = '{1'b0, 2'b10, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1};
    vecs[16] = '{1'b0, 2'b10, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'd0, 32'h08000000, 1};
    vecs[17] = '{1'b0, 2'b11, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 32'd3, 1};
    vecs[18] = '{1'b0, 2'b10, 3'd2, 7'h01, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 33};
    vecs[19] = '{1'b0, 2'b10, 3'd7, 7'h01, 32'd7, 32'd3, 32'd0, 32'd1, 33};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int k = 0; k < 20; k++)
      run_op(vecs[k].src, vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].a, vecs[k].b,
             vecs[k].i, vecs[k].exp, vecs[k].lat, $sformatf("vec%0d", k));

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 3);
      src = 1'b0; op = 2'b10; f7 = 7'h00; f3 = 3'($urandom);
      a = $urandom; b = $urandom; i = $urandom;
      case (kind)
        0: begin
          src = 1'($urandom); op = 2'($urandom);
          f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        3: begin
          f7 = 7'h01;
          f3 = 3'b100 | 3'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) b = 32'd0;
          else begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        end
        default: f7 = 7'h01;
      endcase
      model(src, op, f3, f7, a, b, i, exp, lat);
      run_op(src, op, f3, f7, a, b, i, exp, lat, $sformatf("rand%0d", k));
    end

    // Backpressure: result held, then drain and accept in the same cycle.
    @(negedge clk);
    alu_src = 1'b0; alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'h00;
    rs1_data = 32'd100; rs2_data = 32'd23; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_res", alu_result, 32'd123);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (alu_result !== 32'd123 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    check("bp_stable", {31'b0, ok}, 32'd1);
    alu_op = 2'b10; funct3 = 3'd4; rs1_data = 32'hFF00FF00; rs2_data = 32'h0F0F0F0F;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", {31'b0, out_valid}, 32'd1);
    check("bp_new_res", alu_result, 32'hF00FF00F);

    // Reset in the 10th cycle of a divide.
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'd4; funct7 = 7'h01; alu_src = 1'b0;
    rs1_data = 32'd1000; rs2_data = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("div_busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_result", alu_result, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
    run_op(1'b0, 2'b00, 3'd0, 7'h00, 32'd7, 32'd8, 32'd0, 32'd15, 1, "after_rst_add");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
- Parametrised successor to the combinational execute stage, replacing it in the EX slot of the 5-stage pipeline.
- Performs the RV32I integer ALU operations with one registered cycle of latency.
- Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as iterative multi-cycle operations.
- Uses valid/ready handshakes on both sides so the hazard unit can stall the pipeline.

Parameters:
- XLEN, 32: datapath width. Must be a power of two, at least 8.
- ENABLE_M, 1: when 1, M-extension ops are decoded. When 0, funct7=0000001 is decoded as a plain ALU op and bit 0 of funct7 is ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  block accepts the operation this cycle.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B when alu_src=0.
- imm  in  XLEN  operand B when alu_src=1.
- alu_src  in  1  0 selects rs2_data, 1 selects imm.
- alu_op  in  2  00=ADD, 01=SUB, 10=decode by funct3/funct7, 11=ADD (reserved).
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- out_valid  out  1  alu_result and zero are valid.
- out_ready  in  1  consumer takes the result.
- alu_result  out  XLEN  registered result.
- zero  out  1  registered; 1 when alu_result==0.
- busy  out  1  a multi-cycle operation is in progress.

Behaviour:
- Reset (rst high at a clock edge):
  - FSM goes to IDLE; any operation in flight is discarded.
  - out_valid=0, alu_result=0, zero=0, busy=0.
  - in_ready is 0 while rst is high.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
  - Accept occurs when in_valid && in_ready.
  - Transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, alu_result and zero hold stable.
  - A new result never overwrites an undrained one.
- Decode for alu_op=10, on funct3:
  - 000: ADD; SUB when funct7[5]=1 and alu_src=0. With alu_src=1 it is always ADD.
  - 001: SLL. 010: SLT (signed). 011: SLTU. 100: XOR. 110: OR. 111: AND.
  - 101: SRL, or SRA when funct7[5]=1. This applies for both alu_src values.
  - Shift amount is operand B[log2(XLEN)-1:0].
  - SLT/SLTU write 1 or 0, zero-extended.
- M ops:
  - Selected when ENABLE_M=1, alu_op=10, alu_src=0 and funct7=0000001.
  - funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU in RISC-V order.
- ALU ops: result is registered at the accept edge; out_valid is high in the next cycle (latency 1).
- FSM states:
  - IDLE → MUL on accepting a multiply.
  - IDLE → DIV on accepting a divide/remainder that is not fast-path.
  - MUL/DIV → IDLE after exactly XLEN iteration cycles; the result is loaded into the output register on that edge.
  - M-op latency from the accept edge to out_valid is XLEN+1 cycles (33 at XLEN=32).
  - busy=1 in MUL/DIV.
- Multiply:
  - Shift-add over operand magnitudes, one bit per cycle, with a 2*XLEN product.
  - Sign is applied at the end per op: MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Fast path, latency 1, no DIV state:
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative value, rs2 = -1): quotient = rs1; remainder = 0.
- zero is computed from the final result for every op.
- Operand inputs are sampled only at accept; changes to the inputs afterwards are ignored.

Test Plan:
- ADD 10+20 → 30 with out_valid one cycle after accept. SUB (funct7=0100000) 10-20 → 0xFFFFFFF6, zero=0. SUB 20-20 → 0, zero=1.
- alu_src=1, rs1=10, imm=0x0F0F0F0F, funct3=100 → 0x0F0F0F05. alu_src=1, funct3=000, funct7=0100000 → ADD. SRA of -8 by 1 → 0xFFFFFFFC. SLTU 0xFFFFFFFF vs 1 → 0. SLT -5 vs 10 → 1.
- MUL 0xFFFFFFFF*2 → 0xFFFFFFFE. MULH -8*3 → 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. Each gives out_valid exactly 33 cycles after accept, with busy=1 and in_ready=0 throughout.
- DIV -7/2 → 0xFFFFFFFD. REM -7%2 → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF at latency 1. DIV 0x80000000/-1 → 0x80000000 and REM → 0, both at latency 1.
- Backpressure: hold out_ready=0 with a result pending → result stable and in_ready=0. Then raise out_ready with a new ALU op on in_valid → transfer and accept in the same cycle, and the new result is valid the next cycle.
- Assert rst in the 10th cycle of a DIV → next cycle busy=0, out_valid=0, alu_result=0. After rst drops, in_ready=1 and the next ADD completes correctly with no stale output.
